// File: rtl/spike_enc_pkg.sv
// +----------------------------------------------------------------------+
// | spike_enc_pkg : shared types and LFSR constants for the spike encoder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package spike_enc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } spike_state_t;

   localparam int                LFSR_W    = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/spike_lfsr.sv
// +----------------------------------------------------------------------+
// | spike_lfsr : right-shifting Galois LFSR, steps only when advance=1   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spike_lfsr
   import spike_enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] r_value;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_value <= LFSR_SEED;
      end else if (advance) begin
         r_value <= {1'b0, r_value[LFSR_W-1:1]} ^ (r_value[0] ? LFSR_TAPS : '0);
      end
   end

   assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/spike_rate_encoder.sv
// +----------------------------------------------------------------------+
// | spike_rate_encoder : per-channel intensity to spike-train converter  |
// | Define SPIKE_ENC_LFSR_EN for stochastic (LFSR) encoding.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spike_rate_encoder
   import spike_enc_pkg::*;
#(
   parameter int  N_CH    = 8,
   parameter int  W       = 8,
   parameter int  WIN_LEN = 256,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH_W-1:0] in_ch,
   input  logic [W-1:0]    in_data,
   input  logic            start,
   input  logic            stop,
   output logic [N_CH-1:0] spikes,
   output logic            window_done,
   output logic            busy
);

   localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   spike_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_rate [N_CH];
   logic [N_CH-1:0]  r_spikes;
   logic             r_done;

   logic [N_CH-1:0]  w_fire;
   logic             w_update;
   logic             w_last;
   logic             w_ch_ok;

   assign w_update = ena && (r_state == RUN) && !stop;
   assign w_last   = (r_cnt == CNT_W'(WIN_LEN - 1));

   // Out-of-range channel indices complete the handshake but store nothing
   if (N_CH == (1 << CH_W)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
   end else begin : g_ch_part
      assign w_ch_ok = (in_ch < CH_W'(N_CH));
   end

`ifdef SPIKE_ENC_LFSR_EN
   logic [LFSR_W-1:0] w_lfsr;
   logic              w_unused_lfsr;

   if (N_CH + W - 1 > LFSR_W) begin : g_lfsr_chk
      $error("spike_rate_encoder: N_CH+W-1 exceeds LFSR_W");
   end

   spike_lfsr u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (w_update),
      .value   (w_lfsr)
   );

   assign w_unused_lfsr = ^w_lfsr;

   for (genvar i = 0; i < N_CH; i++) begin : g_fire
      assign w_fire[i] = (w_lfsr[i+W-1:i] < r_rate[i]);
   end
`else
   for (genvar i = 0; i < N_CH; i++) begin : g_acc
      logic [W-1:0] r_acc;
      logic [W:0]   w_sum;

      assign w_sum     = {1'b0, r_acc} + {1'b0, r_rate[i]};
      assign w_fire[i] = w_sum[W];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_acc <= '0;
         end else if (ena && (r_state == IDLE) && start) begin
            r_acc <= '0;
         end else if (w_update) begin
            r_acc <= w_sum[W-1:0];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_spikes <= '0;
         r_done   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_rate[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         if (!ena) begin
            r_spikes <= '0;
         end else begin
            if (in_valid && (r_state == IDLE) && w_ch_ok) begin
               r_rate[in_ch] <= in_data;
            end
            case (r_state)
               IDLE: begin
                  r_spikes <= '0;
                  if (start) begin
                     r_state <= RUN;
                     r_cnt   <= '0;
                  end
               end
               RUN: begin
                  // An abort takes priority over the final update of the window
                  if (stop) begin
                     r_state  <= IDLE;
                     r_spikes <= '0;
                  end else begin
                     r_spikes <= w_fire;
                     r_cnt    <= r_cnt + CNT_W'(1);
                     if (w_last) begin
                        r_state <= DONE;
                     end
                  end
               end
               DONE: begin
                  r_spikes <= '0;
                  r_done   <= 1'b1;
                  r_state  <= IDLE;
               end
               default: begin
                  r_state  <= IDLE;
                  r_spikes <= '0;
               end
            endcase
         end
      end
   end

   assign in_ready    = rst_n && ena && (r_state == IDLE);
   assign spikes      = r_spikes;
   assign window_done = r_done;
   assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder (deterministic build).
`default_nettype none

module tb_spike_rate_encoder;

   localparam int N_CH    = 8;
   localparam int W       = 8;
   localparam int WIN_LEN = 256;
   localparam int CH_W    = 3;

   logic            clk;
   logic            rst_n;
   logic            ena;
   logic            in_valid;
   logic            in_ready;
   logic [CH_W-1:0] in_ch;
   logic [W-1:0]    in_data;
   logic            start;
   logic            stop;
   logic [N_CH-1:0] spikes;
   logic            window_done;
   logic            busy;

   spike_rate_encoder #(
      .N_CH    (N_CH),
      .W       (W),
      .WIN_LEN (WIN_LEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ch       (in_ch),
      .in_data     (in_data),
      .start       (start),
      .stop        (stop),
      .spikes      (spikes),
      .window_done (window_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: stored intensities and last window results
   int m_rate [N_CH];
   int tot    [N_CH];
   int pulses;
   int dur;

   typedef struct {
      int ch;
      int data;
      int exp_total;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // channel with intensity r fires on update k when floor(k*r/2^W) steps up
   function automatic bit fire(input int k, input int r);
      return ((k * r) >> W) != (((k - 1) * r) >> W);
   endfunction

   function automatic int exp_total(input int r);
      return (WIN_LEN * r) >> W;
   endfunction

   task automatic write_rate(input int ch, input int data);
      in_valid = 1'b1;
      in_ch    = CH_W'(ch);
      in_data  = W'(data);
      #1;
      check("write_in_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      m_rate[ch] = data;
   endtask

   task automatic run_window(input int stop_at, input int gap_at, input int gap_len,
                             input bit wr_en, input int wr_ch, input int wr_data,
                             input bit noise);
      int k;
      int gap_left;
      int cyc;
      bit in_done;
      bit fin;
      bit stopping;
      logic [N_CH-1:0] exp_sp;
      bit exp_done;
      bit exp_busy;

      for (int i = 0; i < N_CH; i++) tot[i] = 0;
      pulses = 0;
      ena    = 1'b1;
      stop   = 1'b0;
      start  = 1'b1;
      if (wr_en) begin
         in_valid = 1'b1;
         in_ch    = CH_W'(wr_ch);
         in_data  = W'(wr_data);
         m_rate[wr_ch] = wr_data;
      end
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check("launch_busy", int'(busy), 1);
      check("launch_spikes", int'(spikes), 0);

      k = 0; gap_left = gap_len; cyc = 0; in_done = 0; fin = 0;
      while (!fin && cyc < WIN_LEN + gap_len + 8) begin
         ena = 1'b1;
         if (k == gap_at && gap_left > 0) begin
            ena = 1'b0;
            gap_left--;
         end
         stopping = ena && !in_done && (k == stop_at);
         stop     = stopping;
         if (noise && !in_done) begin
            in_valid = 1'($urandom_range(0, 1));
            in_ch    = CH_W'($urandom_range(0, N_CH - 1));
            in_data  = W'($urandom_range(0, 255));
            start    = 1'($urandom_range(0, 1));
         end
         #1;
         check("run_in_ready", int'(in_ready), 0);
         tick();
         cyc++;
         stop = 1'b0; in_valid = 1'b0; start = 1'b0;

         exp_sp = '0; exp_done = 0; exp_busy = 1;
         if (ena) begin
            if (in_done) begin
               exp_done = 1; exp_busy = 0; fin = 1;
            end else if (stopping) begin
               exp_busy = 0; fin = 1;
            end else begin
               k++;
               for (int i = 0; i < N_CH; i++) exp_sp[i] = fire(k, m_rate[i]);
               if (k == WIN_LEN) in_done = 1;
            end
         end
         check("run_spikes", int'(spikes), int'(exp_sp));
         check("run_window_done", int'(window_done), int'(exp_done));
         check("run_busy", int'(busy), int'(exp_busy));
         for (int i = 0; i < N_CH; i++) tot[i] += int'(spikes[i]);
         pulses += int'(window_done);
      end
      ena = 1'b1;
      if (!fin) begin
         n_checks++;
         n_errors++;
         $display("FAIL window_timeout: got %0d cycles without end, required at most %0d",
                  cyc, WIN_LEN + gap_len + 8);
      end
      dur = cyc;
      #1;
      check("after_in_ready", int'(in_ready), 1);
   endtask

   vec_t vecs [6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{ch: 0, data: 0,   exp_total: 0};
      vecs[1] = '{ch: 1, data: 1,   exp_total: 1};
      vecs[2] = '{ch: 2, data: 255, exp_total: 255};
      vecs[3] = '{ch: 4, data: 3,   exp_total: 3};
      vecs[4] = '{ch: 5, data: 200, exp_total: 200};
      vecs[5] = '{ch: 7, data: 129, exp_total: 129};

      for (int i = 0; i < N_CH; i++) m_rate[i] = 0;
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
      start = 1'b0; stop = 1'b0;
      repeat (3) tick();
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_spikes", int'(spikes), 0);
      check("reset_window_done", int'(window_done), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_spikes", int'(spikes), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_window_done", int'(window_done), 0);

      // write with ena low must be refused
      ena = 1'b0; in_valid = 1'b1; in_ch = 3'd6; in_data = 8'd77;
      #1;
      check("ena_low_in_ready", int'(in_ready), 0);
      tick();
      in_valid = 1'b0; ena = 1'b1;

      // basic window: 128 -> alternate, 64 -> every 4th update
      write_rate(0, 128);
      write_rate(1, 64);
      run_window(-1, -1, 0, 0, 0, 0, 0);
      check("basic_tot0", tot[0], 128);
      check("basic_tot1", tot[1], 64);
      check("basic_tot6", tot[6], 0);
      check("basic_pulses", pulses, 1);
      check("basic_dur", dur, WIN_LEN + 1);

      // writes and starts during RUN are ignored; rates survive
      run_window(-1, -1, 0, 0, 0, 0, 1);
      run_window(-1, -1, 0, 0, 0, 0, 0);
      check("hold_tot0", tot[0], 128);
      check("hold_tot1", tot[1], 64);

      // write and start on the same edge
      run_window(-1, -1, 0, 1, 3, 255, 0);
      check("same_edge_tot3", tot[3], 255);
      check("same_edge_pulses", pulses, 1);

      // abort after 100 updates, then a clean restart
      run_window(100, -1, 0, 0, 0, 0, 0);
      check("stop_pulses", pulses, 0);
      check("stop_dur", dur, 101);
      run_window(-1, -1, 0, 0, 0, 0, 0);
      check("restart_tot0", tot[0], 128);
      check("restart_tot3", tot[3], 255);

      // ena gap of 10 cycles mid-window
      run_window(-1, 50, 10, 0, 0, 0, 0);
      check("gap_dur", dur, WIN_LEN + 1 + 10);
      check("gap_tot0", tot[0], 128);
      check("gap_tot1", tot[1], 64);
      check("gap_tot3", tot[3], 255);
      check("gap_pulses", pulses, 1);

      for (int v = 0; v < 6; v++) begin
         write_rate(vecs[v].ch, vecs[v].data);
         run_window(-1, -1, 0, 0, 0, 0, 0);
         check("table_tot", tot[vecs[v].ch], vecs[v].exp_total);
      end

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N_CH; i++) write_rate(i, int'($urandom_range(0, 255)));
         run_window(-1, int'($urandom_range(1, 200)), int'($urandom_range(0, 5)),
                    0, 0, 0, 1'($urandom_range(0, 1)));
         for (int i = 0; i < N_CH; i++) check("rand_tot", tot[i], exp_total(m_rate[i]));
         check("rand_pulses", pulses, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
